// File: rtl/snn_config_loader.sv
`default_nettype none
// ============================================================================
//  Module   : snn_config_loader
//  Purpose  : Byte-serial loader for the SNN configuration buses. A framed,
//             XOR-checksummed byte stream fills a shadow register; the active
//             buses update atomically only after a frame checks out.
//  Revision : 1.0 - initial release
// ============================================================================
module snn_config_loader #(
  parameter int         W_BYTES = 36,
  parameter int         D_BYTES = 72,
  parameter int         P_BYTES = 3,
  parameter logic [7:0] SYNC    = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 abort,
  input  logic                 enable_in,
  output logic [8*W_BYTES-1:0] weights,
  output logic [8*D_BYTES-1:0] delays,
  output logic [5:0]           threshold,
  output logic [5:0]           decay,
  output logic [5:0]           refractory_period,
  output logic                 net_enable,
  output logic                 cfg_loaded,
  output logic                 cfg_done,
  output logic                 cfg_error,
  output logic                 busy
);

  localparam int c_TOTAL   = W_BYTES + D_BYTES + P_BYTES;
  localparam int c_CNT_W   = $clog2(c_TOTAL);
  localparam int c_WD_BITS = 8 * (W_BYTES + D_BYTES);
  localparam int c_IDX_W   = $clog2(c_WD_BITS);

  // Byte positions of the last frame byte and of the three parameter bytes
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_TOTAL - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_THR  = c_CNT_W'(W_BYTES + D_BYTES);
  localparam logic [c_CNT_W-1:0] c_CNT_DEC  = c_CNT_W'(W_BYTES + D_BYTES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_REF  = c_CNT_W'(W_BYTES + D_BYTES + 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_CHECK  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_in_ready;
  logic                  w_accept;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [7:0]            r_csum;
  logic [c_IDX_W-1:0]    w_bit_base;

  // Shadow copy; only the 6 used bits of each parameter byte are kept
  logic [c_WD_BITS-1:0]  r_sh_wd;
  logic [5:0]            r_sh_thr;
  logic [5:0]            r_sh_dec;
  logic [5:0]            r_sh_ref;

  // Active configuration
  logic [c_WD_BITS-1:0]  r_act_wd;
  logic [5:0]            r_act_thr;
  logic [5:0]            r_act_dec;
  logic [5:0]            r_act_ref;
  logic                  r_cfg_loaded;
  logic                  r_cfg_done;
  logic                  r_cfg_error;

  assign w_accept   = in_valid && w_in_ready;
  assign w_bit_base = c_IDX_W'(r_cnt) << 3;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake: abort wins over everything and refuses the byte
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_in_ready = 1'b1;
          if (in_valid && (in_data == SYNC)) w_state_nxt = S_LOAD;
        end
        S_LOAD: begin
          w_in_ready = 1'b1;
          if (in_valid && (r_cnt == c_CNT_LAST)) w_state_nxt = S_CHECK;
        end
        S_CHECK: begin
          w_in_ready = 1'b1;
          if (in_valid) w_state_nxt = (in_data == r_csum) ? S_COMMIT : S_IDLE;
        end
        S_COMMIT: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Frame datapath: shadow fill, checksum, status pulses and atomic commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_csum       <= '0;
      r_sh_wd      <= '0;
      r_sh_thr     <= '0;
      r_sh_dec     <= '0;
      r_sh_ref     <= '0;
      r_act_wd     <= '0;
      r_act_thr    <= '0;
      r_act_dec    <= '0;
      r_act_ref    <= '0;
      r_cfg_loaded <= 1'b0;
      r_cfg_done   <= 1'b0;
      r_cfg_error  <= 1'b0;
    end else begin
      r_cfg_done  <= 1'b0;
      r_cfg_error <= 1'b0;
      if (!abort) begin
        case (r_state)
          S_IDLE: begin
            if (w_accept && (in_data == SYNC)) begin
              r_cnt  <= '0;
              r_csum <= '0;
            end
          end
          S_LOAD: begin
            if (w_accept) begin
              // Upper bits of parameter bytes are dropped here but still
              // enter the checksum below
              if (r_cnt < c_CNT_THR) begin
                r_sh_wd[w_bit_base +: 8] <= in_data;
              end else if (r_cnt == c_CNT_THR) begin
                r_sh_thr <= in_data[5:0];
              end else if (r_cnt == c_CNT_DEC) begin
                r_sh_dec <= in_data[5:0];
              end else if (r_cnt == c_CNT_REF) begin
                r_sh_ref <= in_data[5:0];
              end
              r_csum <= r_csum ^ in_data;
              r_cnt  <= r_cnt + 1'b1;
            end
          end
          S_CHECK: begin
            if (w_accept && (in_data != r_csum)) r_cfg_error <= 1'b1;
          end
          S_COMMIT: begin
            r_act_wd     <= r_sh_wd;
            r_act_thr    <= r_sh_thr;
            r_act_dec    <= r_sh_dec;
            r_act_ref    <= r_sh_ref;
            r_cfg_loaded <= 1'b1;
            r_cfg_done   <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign in_ready          = w_in_ready;
  assign busy              = (r_state != S_IDLE);
  assign weights           = r_act_wd[8*W_BYTES-1:0];
  assign delays            = r_act_wd[c_WD_BITS-1:8*W_BYTES];
  assign threshold         = r_act_thr;
  assign decay             = r_act_dec;
  assign refractory_period = r_act_ref;
  assign cfg_loaded        = r_cfg_loaded;
  assign cfg_done          = r_cfg_done;
  assign cfg_error         = r_cfg_error;
  assign net_enable        = enable_in && r_cfg_loaded;

endmodule
`default_nettype wire
